// File: rtl/pc_stack_unit_if.sv
// Command and status bundle between a sequencer and pc_stack_unit.
// Commands are sampled on the rising clock edge; status is registered or derived from registers.
// There is no backpressure: every command is accepted in the cycle it is sampled.
interface pc_stack_unit_if #(
    parameter int ADDR_W = 13,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              cen;
    logic              ld;
    logic              call;
    logic              ret;
    logic [ADDR_W-1:0] in;
    logic [ADDR_W-1:0] out;
    logic [CNT_W-1:0]  cnt;
    logic              empty;
    logic              full;
    logic              err_ovf;
    logic              err_unf;

    modport master (
        output cen, ld, call, ret, in,
        input  out, cnt, empty, full, err_ovf, err_unf
    );

    modport slave (
        input  cen, ld, call, ret, in,
        output out, cnt, empty, full, err_ovf, err_unf
    );
endinterface

// File: rtl/pc_stack_unit.sv
// Program counter with a return-address stack (increment, jump, call, return).
// Latency: one edge from a command to out/cnt/flags; no combinational path from commands to out.
// No backpressure: full/empty misuse is flagged (err_ovf/err_unf). Define PC_STACK_CIRC_EN for a circular stack.
module pc_stack_unit #(
    parameter int ADDR_W = 13,
    parameter int DEPTH  = 4
) (
    input  logic           clk,
    input  logic           rst,
    pc_stack_unit_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ADDR_W-1:0] out_q, out_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_unf_q, err_unf_d;
    logic [ADDR_W-1:0] stack_q [DEPTH];

    logic              full, empty;
    logic              push_en;
    logic [IDX_W-1:0]  push_idx;
    logic [IDX_W-1:0]  top_idx;
    logic [ADDR_W-1:0] ret_addr;

    assign full     = (cnt_q == CNT_W'(DEPTH));
    assign empty    = (cnt_q == '0);
    assign ret_addr = stack_q[top_idx];

`ifdef PC_STACK_CIRC_EN
    // Write pointer marks the next slot; when full it also marks the oldest entry.
    logic [IDX_W-1:0] wp_q, wp_d;
    logic [IDX_W-1:0] wp_inc;

    assign push_idx = wp_q;
    assign top_idx  = (wp_q == '0) ? IDX_W'(DEPTH - 1) : IDX_W'(wp_q - 1'b1);
    assign wp_inc   = (wp_q == IDX_W'(DEPTH - 1)) ? '0 : IDX_W'(wp_q + 1'b1);
    assign bus.err_ovf = 1'b0;
`else
    // Linear stack: the fill count doubles as the write index.
    logic err_ovf_q, err_ovf_d;

    assign push_idx    = cnt_q[IDX_W-1:0];
    assign top_idx     = IDX_W'(cnt_q - 1'b1);
    assign bus.err_ovf = err_ovf_q;
`endif

    // Resolve the single winning command (ret > call > ld > cen) into next state.
    always_comb begin
        out_d     = out_q;
        cnt_d     = cnt_q;
        err_unf_d = err_unf_q;
        push_en   = 1'b0;
`ifdef PC_STACK_CIRC_EN
        wp_d      = wp_q;
`else
        err_ovf_d = err_ovf_q;
`endif
        if (bus.ret) begin
            if (!empty) begin
                out_d = ret_addr;
                cnt_d = CNT_W'(cnt_q - 1'b1);
`ifdef PC_STACK_CIRC_EN
                wp_d  = top_idx;
`endif
            end else begin
                err_unf_d = 1'b1;
            end
        end else if (bus.call) begin
            if (!full) begin
                push_en = 1'b1;
                out_d   = bus.in;
                cnt_d   = CNT_W'(cnt_q + 1'b1);
`ifdef PC_STACK_CIRC_EN
                wp_d    = wp_inc;
`endif
            end else begin
`ifdef PC_STACK_CIRC_EN
                // Overwrite the oldest entry; the count stays saturated at DEPTH.
                push_en = 1'b1;
                out_d   = bus.in;
                wp_d    = wp_inc;
`else
                err_ovf_d = 1'b1;
`endif
            end
        end else if (bus.ld) begin
            out_d = bus.in;
        end else if (bus.cen) begin
            out_d = ADDR_W'(out_q + 1'b1);
        end
    end

    // Control state registers with synchronous reset; reset aborts any command.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q     <= '0;
            cnt_q     <= '0;
            err_unf_q <= 1'b0;
`ifdef PC_STACK_CIRC_EN
            wp_q      <= '0;
`else
            err_ovf_q <= 1'b0;
`endif
        end else begin
            out_q     <= out_d;
            cnt_q     <= cnt_d;
            err_unf_q <= err_unf_d;
`ifdef PC_STACK_CIRC_EN
            wp_q      <= wp_d;
`else
            err_ovf_q <= err_ovf_d;
`endif
        end
    end

    // Return-address storage; contents are not reset, only writes are gated by reset.
    always_ff @(posedge clk) begin
        if (!rst && push_en) begin
            stack_q[push_idx] <= ADDR_W'(out_q + 1'b1);
        end
    end

    assign bus.out     = out_q;
    assign bus.cnt     = cnt_q;
    assign bus.empty   = empty;
    assign bus.full    = full;
    assign bus.err_unf = err_unf_q;
endmodule

// File: doc/pc_stack_unit.md
PC_STACK_UNIT -- requirements
Module: pc_stack_unit

Interface
REQ-001 Parameter ADDR_W, default 13, SHALL set the program-counter and return-address width in bits.
REQ-002 Parameter DEPTH, default 4, SHALL set the number of return-stack entries; legal range 2..16.
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 rst  input  1  SHALL be the reset; it is synchronous and active-high.
REQ-005 cen  input  1  SHALL request an increment, out <= out + 1.
REQ-006 ld  input  1  SHALL request a jump, out <= in.
REQ-007 call  input  1  SHALL request a subroutine call: push out + 1, then out <= in.
REQ-008 ret  input  1  SHALL request a return: out <= top of stack, then pop.
REQ-009 in  input  ADDR_W  SHALL carry the jump or call target.
REQ-010 out  output  ADDR_W  SHALL be the current program counter.
REQ-011 cnt  output  $clog2(DEPTH+1)  SHALL be the number of valid stack entries.
REQ-012 empty / full  output  1 each  SHALL be cnt == 0 and cnt == DEPTH, both combinational from cnt.
REQ-013 err_ovf / err_unf  output  1 each  SHALL be sticky overflow and underflow flags.

Function
REQ-014 Command priority per cycle SHALL be rst > ret > call > ld > cen; only the highest asserted command takes effect.
REQ-015 cen SHALL increment out modulo 2^ADDR_W; all-ones wraps to 0 with no flag.
REQ-016 ld SHALL load in into out in one cycle; cnt and the stack are unchanged.
REQ-017 call with full == 0 SHALL, in the same edge:
  - write out + 1 (mod 2^ADDR_W) into entry cnt;
  - increment cnt;
  - load in into out.
REQ-018 ret with empty == 0 SHALL, in the same edge, load entry cnt-1 into out and decrement cnt.
REQ-019 ret with empty == 1 SHALL leave out, cnt and the stack unchanged, and SHALL set err_unf.
REQ-020 call with full == 1 SHALL follow the Configuration section.
REQ-021 With no command asserted, all state SHALL hold.
REQ-022 The stack SHALL be a LIFO; entries at index >= cnt are don't-care and SHALL NOT be observable on out.
REQ-023 err_ovf and err_unf SHALL clear only on rst.
REQ-024 Latency: every command SHALL be visible on out, cnt and the flags one clock edge after it is sampled; no combinational path from a command input to out.

Reset
REQ-025 On a rising clk edge with rst = 1, the block SHALL set out = 0, cnt = 0, err_ovf = 0 and err_unf = 0, regardless of other inputs.
REQ-026 Stack entry contents need not be reset.
REQ-027 rst asserted during any command SHALL abort that command; the command SHALL have no effect.

Configuration
REQ-028 Macro PC_STACK_CIRC_EN SHALL select the full-stack behaviour.
REQ-029 Without PC_STACK_CIRC_EN, call when full == 1 SHALL:
  - leave out, cnt and the stack unchanged;
  - set err_ovf.
REQ-030 With PC_STACK_CIRC_EN, the stack SHALL be a circular buffer, and call when full == 1 SHALL:
  - overwrite the oldest entry with out + 1;
  - load in into out;
  - keep cnt = DEPTH;
  - never set err_ovf; err_ovf SHALL be tied to 0.
  A later ret SHALL return the newest entries first; after DEPTH rets the stack is empty.

Verification
REQ-031 rst = 1 with cen = 1, then rst = 0 and cen held for 3 cycles -> out = 0 after the reset edge, then 1, 2, 3; cnt = 0.
REQ-032 ADDR_W = 13, out = 0x1FFF, cen for one cycle -> out = 0x0000, no flag set.
REQ-033 Sequence:
  - out = 0x010, call in = 0x200 -> out = 0x200, cnt = 1;
  - call in = 0x300 -> out = 0x300, cnt = 2;
  - ret -> out = 0x201, cnt = 1;
  - ret -> out = 0x011, cnt = 0, empty = 1.
REQ-034 Sequence:
  - ret on an empty stack -> out unchanged, err_unf = 1;
  - ld in = 0x055 -> out = 0x055, err_unf stays 1;
  - rst -> err_unf = 0.
REQ-035 ret, call, ld and cen all asserted together with cnt = 1 and top entry = 0x0AA -> out = 0x0AA, cnt = 0; call, ld and cen are ignored.
REQ-036 DEPTH = 4 with 5 consecutive calls from out = 0x000, targets 0x100, 0x200, 0x300, 0x400, 0x500:
  - macro off: 5th call ignored, out = 0x400, err_ovf = 1;
  - macro on: out = 0x500, cnt = 4; 4 rets -> out = 0x401, 0x301, 0x201, 0x101, then empty = 1.
